pwm_dimmer: RTL and testbench

PWM_DIMMER -- requirements
Module: pwm_dimmer

---
 rtl/pwm_dimmer.sv | 115 +++++++++++
 tb/tb_pwm_dimmer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_dimmer.sv
// Push-button PWM dimmer: debounced up/down/off-restore buttons pick a brightness level,
// and the PWM duty fades toward that level's target once per PWM period.
`timescale 1ns/1ps
module pwm_dimmer #(
    parameter int CLK_DIV         = 100,
    parameter int PWM_BITS        = 10,
    parameter int LEVELS          = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FADE_STEP       = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [2:0]                i_button,
    output logic                      o_pwm,
    output logic [$clog2(LEVELS)-1:0] o_level,
    output logic                      o_fading
);

    localparam int LW  = $clog2(LEVELS);
    localparam int DW  = PWM_BITS;
    localparam int TW  = PWM_BITS + LW;
    localparam int PSW = $clog2(CLK_DIV + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] MAX = {DW{1'b1}};

    logic [2:0]     sync1, sync2;
    logic [DBW-1:0] db_cnt [3];
    logic [2:0]     press;
    logic [LW-1:0]  level, memory;
    logic [PSW-1:0] presc;
    logic           tick, boundary;
    logic [DW-1:0]  pwm_cnt, cnt_nxt;
    logic [DW-1:0]  duty, duty_nxt, target;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_button;
            sync2 <= sync1;
        end
    end

    // Remaining-cycles timer per button, reloaded while low; it sits at zero once a
    // held press has fired, so holding never produces a second pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
            press <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!sync2[i])
                    db_cnt[i] <= DBW'(DEBOUNCE_CYCLES);
                else if (db_cnt[i] != '0)
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                press[i] <= sync2[i] && (db_cnt[i] == DBW'(1));
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            level  <= '0;
            memory <= LW'(LEVELS - 1);
        end else if (press[2]) begin
            if (level != '0) begin
                memory <= level;
                level  <= '0;
            end else begin
                level <= memory;
            end
        end else if (press[0] && !press[1]) begin
            if (level != LW'(LEVELS - 1)) level <= level + 1'b1;
        end else if (press[1] && !press[0]) begin
            if (level != '0) level <= level - 1'b1;
        end
    end

    assign tick     = (presc == '0);
    assign boundary = tick && (pwm_cnt == MAX);
    assign cnt_nxt  = tick ? pwm_cnt + 1'b1 : pwm_cnt;
    assign target   = DW'((TW'(level) * TW'(MAX)) / TW'(LEVELS - 1));

    always_comb begin
        duty_nxt = duty;
        if (boundary) begin
            if (FADE_STEP == 0)
                duty_nxt = target;
            else if (duty < target)
                duty_nxt = (int'(target) - int'(duty) > FADE_STEP) ? duty + DW'(FADE_STEP) : target;
            else if (duty > target)
                duty_nxt = (int'(duty) - int'(target) > FADE_STEP) ? duty - DW'(FADE_STEP) : target;
        end
    end

    // o_pwm is computed from next-state counter/duty so it lines up with the registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
            duty    <= '0;
            o_pwm   <= 1'b0;
        end else begin
            presc   <= tick ? PSW'(CLK_DIV - 1) : presc - 1'b1;
            pwm_cnt <= cnt_nxt;
            duty    <= duty_nxt;
            o_pwm   <= (duty_nxt == MAX) || (cnt_nxt < duty_nxt);
        end
    end

    assign o_level  = level;
    assign o_fading = (duty != target);

endmodule

// File: tb/tb_pwm_dimmer.sv
// Bench for pwm_dimmer: an arithmetic model of levels, press detection and fading is
// compared with the DUT every cycle, alongside directed literal expectations.
`timescale 1ns/1ps
module tb_pwm_dimmer;
    localparam int CLK_DIV   = 1;
    localparam int PWM_BITS  = 4;
    localparam int LEVELS    = 4;
    localparam int DEB       = 3;
    localparam int FADE_STEP = 5;
    localparam int MAXV      = 15;
    localparam int PERIOD    = 16;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [2:0] i_button = 3'b000;
    logic       o_pwm;
    logic [1:0] o_level;
    logic       o_fading;

    int checks = 0;
    int errors = 0;

    int         m_n, m_level, m_mem, m_duty;
    int         m_run [3];
    logic [2:0] m_d1, m_d2, m_sync, m_pend;

    pwm_dimmer #(
        .CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS), .LEVELS(LEVELS),
        .DEBOUNCE_CYCLES(DEB), .FADE_STEP(FADE_STEP)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_button(i_button),
        .o_pwm(o_pwm), .o_level(o_level), .o_fading(o_fading)
    );

    always #5 i_clk = ~i_clk;

    function automatic int tgt(int lvl);
        return (lvl * MAXV) / (LEVELS - 1);
    endfunction

    function automatic int fade(int d, int t);
        if (FADE_STEP == 0) return t;
        if (d < t) return (d + FADE_STEP > t) ? t : d + FADE_STEP;
        return (d - FADE_STEP < t) ? t : d - FADE_STEP;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_level = 0; m_mem = LEVELS - 1; m_duty = 0;
        m_d1 = '0; m_d2 = '0; m_sync = '0; m_pend = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    // One clock edge of the behavioural model: m_n counts edges since reset release.
    task automatic model_step();
        if (m_n % PERIOD == MAXV) m_duty = fade(m_duty, tgt(m_level));
        if (m_pend[2]) begin
            if (m_level != 0) begin m_mem = m_level; m_level = 0; end
            else m_level = m_mem;
        end else if (m_pend[0] && !m_pend[1]) begin
            if (m_level < LEVELS - 1) m_level = m_level + 1;
        end else if (m_pend[1] && !m_pend[0]) begin
            if (m_level > 0) m_level = m_level - 1;
        end
        m_sync = m_d2; m_d2 = m_d1; m_d1 = i_button;
        for (int i = 0; i < 3; i++) begin
            if (m_sync[i]) begin
                if (m_run[i] <= DEB) m_run[i] = m_run[i] + 1;
            end else begin
                m_run[i] = 0;
            end
            m_pend[i] = (m_run[i] == DEB);
        end
        m_n++;
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (!i_reset) model_step();
        @(negedge i_clk);
        chk("model_level", int'(o_level), m_level);
        chk("model_pwm", int'(o_pwm), ((m_duty == MAXV) || ((m_n % PERIOD) < m_duty)) ? 1 : 0);
        chk("model_fading", int'(o_fading), (m_duty != tgt(m_level)) ? 1 : 0);
    endtask

    task automatic press(logic [2:0] mask, int hold);
        i_button = mask;
        repeat (hold) tick();
        i_button = 3'b000;
        repeat (8) tick();
    endtask

    task automatic wait_settle(string name, int budget);
        int k = 0;
        while (o_fading && k < budget) begin tick(); k++; end
        chk(name, int'(o_fading), 0);
    endtask

    task automatic count_high(string name, int want);
        int h = 0;
        for (int i = 0; i < PERIOD; i++) begin tick(); h += int'(o_pwm); end
        chk(name, h, want);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        chk("reset_level", int'(o_level), 0);
        chk("reset_pwm", int'(o_pwm), 0);
        chk("reset_fading", int'(o_fading), 0);
        i_reset = 1'b0;

        press(3'b001, 10);
        chk("up_level1", int'(o_level), 1);
        wait_settle("settle_l1", 40);
        count_high("high_l1", 5);

        repeat (3) press(3'b001, 10);
        chk("up_saturate", int'(o_level), 3);
        wait_settle("settle_l3", 100);
        count_high("high_l3", 16);

        press(3'b100, 10);
        chk("off_level", int'(o_level), 0);
        wait_settle("settle_off", 100);
        count_high("high_off", 0);
        press(3'b100, 10);
        chk("restore_level", int'(o_level), 3);
        wait_settle("settle_restore", 100);

        i_button = 3'b001; repeat (2) tick();
        i_button = 3'b000; tick();
        i_button = 3'b001; repeat (2) tick();
        i_button = 3'b000; repeat (8) tick();
        chk("bounce_level", int'(o_level), 3);

        press(3'b011, 10);
        chk("updown_level", int'(o_level), 3);
        press(3'b010, 10);
        chk("down_level", int'(o_level), 2);
        press(3'b101, 10);
        chk("upoff_level", int'(o_level), 0);
        press(3'b010, 10);
        chk("down_sat0", int'(o_level), 0);
        press(3'b100, 10);
        chk("restore_mem2", int'(o_level), 2);
        wait_settle("settle_l2", 100);

        press(3'b100, 10);
        begin
            int k = 0;
            while (!(o_pwm && o_fading) && k < 40) begin tick(); k++; end
            chk("pre_reset_midfade", int'(o_pwm && o_fading), 1);
        end
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_pwm", int'(o_pwm), 0);
        chk("async_rst_level", int'(o_level), 0);
        chk("async_rst_fading", int'(o_fading), 0);
        i_button = 3'b001;
        repeat (3) tick();
        i_reset = 1'b0;
        repeat (10) tick();
        i_button = 3'b000;
        repeat (8) tick();
        chk("post_reset_level1", int'(o_level), 1);
        wait_settle("post_reset_settle", 40);
        count_high("post_reset_high", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
